// File: rtl/ct_f_spsram_ctrl_pkg.sv
// +--------------------------------------------------------------------------+
// | ct_f_spsram_ctrl_pkg: shared types and constants for the SRAM controller  |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
`default_nettype none

package ct_f_spsram_ctrl_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int          RSP_DEPTH   = 2;
  localparam logic        CEN_OFF     = 1'b1;
  localparam logic        GWEN_OFF    = 1'b1;
  localparam logic [63:0] WEN_ALL_OFF = '1;

endpackage

`default_nettype wire

// File: rtl/ct_f_spsram_ctrl_rsp_buf.sv
// +--------------------------------------------------------------------------+
// | ct_f_spsram_ctrl_rsp_buf: 2-entry read-response FIFO                      |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
`default_nettype none

module ct_f_spsram_ctrl_rsp_buf
  import ct_f_spsram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  head_vld,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [1:0]            occupancy
);

  logic [DATA_WIDTH-1:0] mem [RSP_DEPTH];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            count;
  logic                  pop_ok;
  logic                  push_ok;

  assign pop_ok    = pop && (count != 2'd0);
  assign push_ok   = push && ((count != 2'd2) || pop_ok);
  assign head_vld  = (count != 2'd0);
  assign head_data = mem[rd_ptr];
  assign occupancy = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

endmodule

`default_nettype wire

// File: rtl/ct_f_spsram_ctrl.sv
// +--------------------------------------------------------------------------+
// | ct_f_spsram_ctrl: valid/ready front end for a single-port SRAM macro      |
// | Optional post-reset clear sweep: CT_F_SPSRAM_CTRL_INIT_EN                  |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
`default_nettype none

module ct_f_spsram_ctrl
  import ct_f_spsram_ctrl_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 9,
  parameter int                    DATA_WIDTH = 7,
  parameter int                    DEPTH      = 512,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_bmask,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  state_t                state;
  state_t                state_nxt;
  logic                  rd_inflight;
  logic [1:0]            occupancy;
  logic [ADDR_WIDTH-1:0] a_hold;
  logic [DATA_WIDTH-1:0] d_hold;
  logic                  accept;
  logic                  sweep;
  logic                  sweep_last;
  logic [ADDR_WIDTH-1:0] sweep_addr;

`ifdef CT_F_SPSRAM_CTRL_INIT_EN
  localparam state_t ST_RESET = ST_INIT;
  logic [ADDR_WIDTH-1:0] init_cnt;

  // Gated by the reset pin so the macro stays quiet while reset is held.
  assign sweep      = (state == ST_INIT) && cpurst_b;
  assign sweep_addr = init_cnt;

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      init_cnt  <= '0;
      init_done <= 1'b0;
    end else if (sweep) begin
      if (sweep_last) init_done <= 1'b1;
      else            init_cnt  <= init_cnt + 1'b1;
    end
  end
`else
  localparam state_t ST_RESET = ST_RUN;

  assign sweep      = 1'b0;
  assign sweep_addr = '0;

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) init_done <= 1'b0;
    else           init_done <= 1'b1;
  end
`endif

  assign sweep_last = (sweep_addr == ADDR_WIDTH'(DEPTH - 1));

  // Credit uses registered occupancy only, so rsp_rdy never reaches req_rdy.
  assign req_rdy = (state == ST_RUN) && init_done &&
                   (({1'b0, occupancy} + {2'b00, rd_inflight}) < 3'd2);
  assign accept  = req_vld && req_rdy;

  always_comb begin
    state_nxt = state;
    sram_cen  = CEN_OFF;
    sram_gwen = GWEN_OFF;
    sram_wen  = WEN_ALL_OFF[DATA_WIDTH-1:0];
    sram_a    = a_hold;
    sram_d    = d_hold;
    case (state)
      ST_INIT: begin
        if (sweep) begin
          sram_cen  = 1'b0;
          sram_gwen = 1'b0;
          sram_wen  = '0;
          sram_a    = sweep_addr;
          sram_d    = INIT_VAL;
          if (sweep_last) state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept) begin
          sram_cen = 1'b0;
          sram_a   = req_addr;
          if (req_wr) begin
            sram_gwen = 1'b0;
            sram_wen  = ~req_bmask;
            sram_d    = req_wdata;
          end
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state       <= ST_RESET;
      rd_inflight <= 1'b0;
      a_hold      <= '0;
      d_hold      <= '0;
    end else begin
      state       <= state_nxt;
      rd_inflight <= accept && !req_wr;
      a_hold      <= sram_a;
      d_hold      <= sram_d;
    end
  end

  ct_f_spsram_ctrl_rsp_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rsp_buf (
    .clk       (forever_cpuclk),
    .rst_n     (cpurst_b),
    .push      (rd_inflight),
    .push_data (sram_q),
    .pop       (rsp_rdy),
    .head_vld  (rsp_vld),
    .head_data (rsp_rdata),
    .occupancy (occupancy)
  );

endmodule

`default_nettype wire

// File: tb/tb_ct_f_spsram_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_ct_f_spsram_ctrl: scoreboard bench with a behavioural 512x7 macro      |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_ct_f_spsram_ctrl;

  localparam int            AW       = 9;
  localparam int            DW       = 7;
  localparam int            DEPTH    = 512;
  localparam logic [DW-1:0] INIT_VAL = '0;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          req_vld   = 1'b0;
  logic          req_wr    = 1'b0;
  logic [AW-1:0] req_addr  = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [DW-1:0] req_bmask = '0;
  logic          rsp_rdy   = 1'b0;
  logic          req_rdy;
  logic          rsp_vld;
  logic [DW-1:0] rsp_rdata;
  logic          init_done;
  logic [AW-1:0] sram_a;
  logic          sram_cen;
  logic          sram_gwen;
  logic [DW-1:0] sram_wen;
  logic [DW-1:0] sram_d;
  logic [DW-1:0] sram_q;

  int n_vec = 0;
  int n_bad = 0;
  int n_rsp = 0;

  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] ref_mem [DEPTH];
  logic          init_done_prev = 1'b0;

  always #5 clk = ~clk;

  ct_f_spsram_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .INIT_VAL   (INIT_VAL)
  ) dut (
    .forever_cpuclk (clk),
    .cpurst_b       (rst_n),
    .req_vld        (req_vld),
    .req_rdy        (req_rdy),
    .req_wr         (req_wr),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_bmask      (req_bmask),
    .rsp_vld        (rsp_vld),
    .rsp_rdy        (rsp_rdy),
    .rsp_rdata      (rsp_rdata),
    .init_done      (init_done),
    .sram_a         (sram_a),
    .sram_cen       (sram_cen),
    .sram_gwen      (sram_gwen),
    .sram_wen       (sram_wen),
    .sram_d         (sram_d),
    .sram_q         (sram_q)
  );

  // Behavioural single-port macro; seeded with noise so the clear sweep matters.
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] q_r    = '0;
  bit            seeded = 1'b0;

  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= DW'($urandom);
      seeded <= 1'b1;
    end else if (!sram_cen) begin
      if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else            q_r <= mem[sram_a];
    end
  end
  assign sram_q = q_r;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: expectations pushed on read accept, compared on response pop.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (rsp_vld && rsp_rdy) begin
        if (exp_q.size() == 0) begin
          check_val("rsp_spurious", 32'(rsp_vld), 32'd0);
        end else begin
          check_val("rsp_data", 32'(rsp_rdata), 32'(exp_q.pop_front()));
          n_rsp++;
        end
      end
      if (req_vld && req_rdy) begin
        if (req_wr) ref_mem[req_addr] = (ref_mem[req_addr] & ~req_bmask) | (req_wdata & req_bmask);
        else        exp_q.push_back(ref_mem[req_addr]);
      end
`ifdef CT_F_SPSRAM_CTRL_INIT_EN
      if (init_done && !init_done_prev) begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = INIT_VAL;
      end
`endif
    end
    init_done_prev = init_done;
  end

  task automatic wait_acc();
    int t = 0;
    @(negedge clk);
    while (!req_rdy && t < 64) begin
      t++;
      @(negedge clk);
    end
    if (!req_rdy) check_val("req_timeout", 32'(req_rdy), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic do_req(input logic wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input logic [DW-1:0] bm);
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wd;
    req_bmask = bm;
    req_vld   = 1'b1;
    wait_acc();
    req_vld   = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 64) begin
      t++;
      @(posedge clk); #1;
    end
    check_val("drain", 32'(exp_q.size()), 32'd0);
  endtask

`ifdef CT_F_SPSRAM_CTRL_INIT_EN
  task automatic run_sweep(input int stop_at, output int n);
    n = 0;
    while (!init_done && n < stop_at) begin
      n++;
      @(posedge clk); #1;
    end
  endtask
`endif

  initial begin
    int n;
    int rsp_before;

    repeat (3) @(posedge clk);
    #1;
    check_val("rst_cen",   32'(sram_cen),  32'd1);
    check_val("rst_gwen",  32'(sram_gwen), 32'd1);
    check_val("rst_wen",   32'(sram_wen),  32'h7f);
    check_val("rst_a",     32'(sram_a),    32'd0);
    check_val("rst_d",     32'(sram_d),    32'd0);
    check_val("rst_rdy",   32'(req_rdy),   32'd0);
    check_val("rst_vld",   32'(rsp_vld),   32'd0);
    check_val("rst_rdata", 32'(rsp_rdata), 32'd0);
    check_val("rst_done",  32'(init_done), 32'd0);
    rst_n = 1'b1;
    #1;

`ifdef CT_F_SPSRAM_CTRL_INIT_EN
    check_val("sweep_cen", 32'(sram_cen), 32'd0);
    check_val("sweep_a0",  32'(sram_a),   32'd0);
    run_sweep(2000, n);
    check_val("init_cycles", 32'(n), 32'd512);
`else
    @(posedge clk); #1;
    check_val("run_rdy_first", 32'(req_rdy),   32'd1);
    check_val("run_done",      32'(init_done), 32'd1);
    do_req(1'b1, 9'd0,   7'h11, 7'h7f);
    do_req(1'b1, 9'd255, 7'h22, 7'h7f);
    do_req(1'b1, 9'd511, 7'h33, 7'h7f);
`endif

    // Reads of boundary addresses
    rsp_rdy = 1'b1;
    do_req(1'b0, 9'd0,   '0, '0);
    do_req(1'b0, 9'd255, '0, '0);
    do_req(1'b0, 9'd511, '0, '0);
    drain();

    // Write then read, response latency
    do_req(1'b1, 9'h1a5, 7'h5a, 7'h7f);
    do_req(1'b0, 9'h1a5, '0, '0);
    check_val("rd_lat0", 32'(rsp_vld), 32'd0);
    @(posedge clk); #1;
    check_val("rd_lat1", 32'(rsp_vld), 32'd1);
    drain();

    // Partial mask, plus a zero-mask write that must change nothing
    do_req(1'b1, 9'h033, 7'h7f, 7'h7f);
    do_req(1'b1, 9'h033, 7'h00, 7'h0f);
    do_req(1'b1, 9'h033, 7'h00, 7'h00);
    do_req(1'b0, 9'h033, '0, '0);
    drain();

    // Back-pressure with three queued reads
    do_req(1'b1, 9'h010, 7'h11, 7'h7f);
    do_req(1'b1, 9'h011, 7'h22, 7'h7f);
    do_req(1'b1, 9'h012, 7'h33, 7'h7f);
    rsp_rdy  = 1'b0;
    req_wr   = 1'b0;
    req_addr = 9'h010;
    req_vld  = 1'b1;
    @(negedge clk);
    check_val("bp_rdy_a", 32'(req_rdy), 32'd1);
    @(posedge clk); #1;
    req_addr = 9'h011;
    @(negedge clk);
    check_val("bp_rdy_b", 32'(req_rdy), 32'd1);
    @(posedge clk); #1;
    req_addr = 9'h012;
    repeat (5) begin
      @(negedge clk);
      check_val("bp_block", 32'(req_rdy), 32'd0);
    end
    check_val("bp_vld", 32'(rsp_vld), 32'd1);
    @(posedge clk); #1;
    rsp_rdy = 1'b1;
    wait_acc();
    req_vld = 1'b0;
    drain();

    // Reset with one response buffered
    rsp_rdy = 1'b0;
    do_req(1'b0, 9'h1a5, '0, '0);
    @(posedge clk); #1;
    check_val("pre_rst_vld", 32'(rsp_vld), 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("arst_vld", 32'(rsp_vld),  32'd0);
    check_val("arst_cen", 32'(sram_cen), 32'd1);
    check_val("arst_rdy", 32'(req_rdy),  32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
`ifdef CT_F_SPSRAM_CTRL_INIT_EN
    check_val("restart_a0", 32'(sram_a), 32'd0);
    run_sweep(100, n);
    check_val("sweep_a100", 32'(sram_a), 32'd100);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_cen", 32'(sram_cen), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check_val("resweep_a0",  32'(sram_a),   32'd0);
    check_val("resweep_cen", 32'(sram_cen), 32'd0);
    run_sweep(2000, n);
    check_val("reinit_cycles", 32'(n), 32'd512);
`else
    @(posedge clk); #1;
    check_val("post_rst_rdy", 32'(req_rdy), 32'd1);
`endif
    check_val("post_rst_vld", 32'(rsp_vld), 32'd0);
    rsp_rdy = 1'b1;
    do_req(1'b0, 9'h1a5, '0, '0);
    drain();

    // Streaming reads with the consumer always ready
    for (int i = 0; i < 8; i++) do_req(1'b1, AW'(9'h040 + i), DW'(i * 13 + 5), 7'h7f);
    rsp_before = n_rsp;
    req_wr  = 1'b0;
    req_vld = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req_addr = AW'(9'h040 + i);
      wait_acc();
    end
    req_vld = 1'b0;
    drain();
    check_val("stream_cnt", 32'(n_rsp - rsp_before), 32'd8);
    @(posedge clk); #1;
    check_val("end_vld", 32'(rsp_vld), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
